// File: rtl/sketch_cm_multi.sv
// Count-min sketch engine: D hashed rows, each backed by an external
// synchronous-read RAM. Three-cycle request pipeline (index, read, update)
// with one-deep write forwarding, plus a drain/clear FSM for table wipes.

module sketch_cm_row #(
    parameter int          HW   = 10,
    parameter int          DW   = 64,
    parameter int          CW   = 32,
    parameter logic [31:0] SEED = 32'h0
) (
    input  logic [DW-1:0] hin_i,
    output logic [HW-1:0] idx_o,
    input  logic [HW-1:0] addr_i,
    input  logic [CW-1:0] rd_data_i,
    input  logic          fwd_en_i,
    input  logic [HW-1:0] fwd_addr_i,
    input  logic [CW-1:0] fwd_data_i,
    output logic [CW-1:0] cnt_o
);
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic [DW-1:0] msg;
    logic [31:0]   crc;

    // MSB-first CRC-32 over the seeded hash input; low HW bits pick the counter
    always_comb begin
        msg = hin_i ^ {(DW/32){SEED}};
        crc = 32'hFFFF_FFFF;
        for (int i = DW - 1; i >= 0; i--) begin
            if (crc[31] ^ msg[i]) crc = (crc << 1) ^ POLY;
            else                  crc = crc << 1;
        end
        idx_o = crc[HW-1:0];
    end

    // A write issued in the same cycle as our RAM read is not visible in the
    // returned data, so substitute it here.
    assign cnt_o = (fwd_en_i && fwd_addr_i == addr_i) ? fwd_data_i : rd_data_i;
endmodule

module sketch_cm_multi #(
    parameter int HW         = 10,
    parameter int DW         = 64,
    parameter int CW         = 32,
    parameter int D          = 4,
    parameter int CU         = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic [DW-1:0]   req_key_i,
    input  logic [DW-1:0]   req_lat_i,
    output logic            resp_valid_o,
    output logic [CW-1:0]   resp_est_o,
    output logic            resp_sat_o,
    output logic [D-1:0]    ram_rd_en_o,
    output logic [D*HW-1:0] ram_rd_addr_o,
    input  logic [D*CW-1:0] ram_rd_data_i,
    output logic [D-1:0]    ram_wr_en_o,
    output logic [D*HW-1:0] ram_wr_addr_o,
    output logic [D*CW-1:0] ram_wr_data_o
);
    localparam int            STAGES = 2;
    localparam logic [CW-1:0] CMAX   = '1;
    localparam logic [HW-1:0] IMAX   = '1;

    typedef enum logic [1:0] {INIT, RUN, DRAIN, CLEAR} state_t;

    state_t               state_q;
    logic                 ready_q, clr_on_q;
    logic [HW-1:0]        clr_idx_q;
    logic [STAGES:1]      vld_pipe_q, ins_pipe_q;
    logic [D-1:0][HW-1:0] idx_s0, idx1_q, idx2_q;
    logic [D-1:0][CW-1:0] cnt_s2, new_s2;
    logic [D-1:0]         wr_s2;
    logic [D-1:0]         fwd_en_q;
    logic [D-1:0][HW-1:0] fwd_addr_q;
    logic [D-1:0][CW-1:0] fwd_data_q;
    logic [D-1:0]         wr_en_d;
    logic [D-1:0][HW-1:0] wr_addr_d;
    logic [D-1:0][CW-1:0] wr_data_d;
    logic [CW-1:0]        min_s2, est_s2;
    logic                 sat_s2;
    logic                 resp_valid_q, resp_sat_q;
    logic [CW-1:0]        resp_est_q;
    logic                 accept, acc_clear, acc_lookup;

    assign accept     = req_valid_i & ready_q;
    assign acc_clear  = accept & (req_op_i == 2'b10);
    assign acc_lookup = accept & ~acc_clear;

    for (genvar r = 0; r < D; r++) begin : g_row
        sketch_cm_row #(
            .HW(HW), .DW(DW), .CW(CW), .SEED(32'(32'h9E37_79B9 * (r + 1)))
        ) u_row (
            .hin_i      ({req_key_i[DW/2-1:0], req_lat_i[DW/2-1:0]}),
            .idx_o      (idx_s0[r]),
            .addr_i     (idx2_q[r]),
            .rd_data_i  (ram_rd_data_i[r*CW +: CW]),
            .fwd_en_i   (fwd_en_q[r]),
            .fwd_addr_i (fwd_addr_q[r]),
            .fwd_data_i (fwd_data_q[r]),
            .cnt_o      (cnt_s2[r])
        );
    end

    // Stage 2 update: saturating increment, conservative-update row selection,
    // post-update minimum and saturation flag
    always_comb begin
        min_s2 = CMAX;
        for (int r = 0; r < D; r++)
            if (cnt_s2[r] < min_s2) min_s2 = cnt_s2[r];
        wr_s2  = '0;
        new_s2 = cnt_s2;
        est_s2 = CMAX;
        sat_s2 = 1'b0;
        for (int r = 0; r < D; r++) begin
            wr_s2[r]  = vld_pipe_q[STAGES] && ins_pipe_q[STAGES] && cnt_s2[r] != CMAX &&
                        (CU == 0 || cnt_s2[r] == min_s2);
            new_s2[r] = wr_s2[r] ? cnt_s2[r] + 1'b1 : cnt_s2[r];
            if (new_s2[r] < est_s2) est_s2 = new_s2[r];
            if (new_s2[r] == CMAX)  sat_s2 = 1'b1;
        end
    end

    // RAM write port: clear sweep owns it while active, otherwise stage-2 updates
    always_comb begin
        wr_en_d   = '0;
        wr_addr_d = '0;
        wr_data_d = '0;
        for (int r = 0; r < D; r++) begin
            if (clr_on_q) begin
                wr_en_d[r]   = 1'b1;
                wr_addr_d[r] = clr_idx_q;
            end else if (wr_s2[r]) begin
                wr_en_d[r]   = 1'b1;
                wr_addr_d[r] = idx2_q[r];
                wr_data_d[r] = new_s2[r];
            end
        end
    end

    // Request pipeline and forwarding register (last cycle's actual writes)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_q <= '0;
            ins_pipe_q <= '0;
            idx1_q     <= '0;
            idx2_q     <= '0;
            fwd_en_q   <= '0;
            fwd_addr_q <= '0;
            fwd_data_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], acc_lookup};
            ins_pipe_q <= {ins_pipe_q[STAGES-1:1], acc_lookup && req_op_i == 2'b00};
            idx1_q     <= acc_lookup ? idx_s0 : '0;
            idx2_q     <= idx1_q;
            fwd_en_q   <= wr_en_d;
            fwd_addr_q <= wr_addr_d;
            fwd_data_q <= wr_data_d;
        end
    end

    // Control FSM with registered ready and response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= (INIT_CLEAR != 0) ? INIT : RUN;
            ready_q      <= 1'b0;
            clr_on_q     <= 1'b0;
            clr_idx_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_est_q   <= '0;
            resp_sat_q   <= 1'b0;
        end else begin
            resp_valid_q <= vld_pipe_q[STAGES];
            resp_est_q   <= vld_pipe_q[STAGES] ? est_s2 : '0;
            resp_sat_q   <= vld_pipe_q[STAGES] & sat_s2;
            case (state_q)
                INIT, CLEAR: begin
                    ready_q  <= 1'b0;
                    clr_on_q <= 1'b1;
                    if (clr_on_q) begin
                        clr_idx_q <= clr_idx_q + 1'b1;
                        if (clr_idx_q == IMAX) begin
                            state_q  <= RUN;
                            ready_q  <= 1'b1;
                            clr_on_q <= 1'b0;
                            // only a requested clear owes its source a response
                            if (state_q == CLEAR) begin
                                resp_valid_q <= 1'b1;
                                resp_est_q   <= '0;
                                resp_sat_q   <= 1'b0;
                            end
                        end
                    end
                end
                RUN: begin
                    ready_q <= ~acc_clear;
                    if (acc_clear) state_q <= DRAIN;
                end
                DRAIN: begin
                    ready_q <= 1'b0;
                    if (vld_pipe_q == '0) begin
                        state_q   <= CLEAR;
                        clr_on_q  <= 1'b1;
                        clr_idx_q <= '0;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign req_ready_o   = ready_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_est_o    = resp_est_q;
    assign resp_sat_o    = resp_sat_q;
    assign ram_rd_en_o   = {D{vld_pipe_q[1]}};
    assign ram_rd_addr_o = idx1_q;
    assign ram_wr_en_o   = wr_en_d;
    assign ram_wr_addr_o = wr_addr_d;
    assign ram_wr_data_o = wr_data_d;
endmodule

// File: tb/tb_sketch_cm_multi.sv
// Bench for sketch_cm_multi: small config (HW=4, CW=4, D=2, conservative
// update), bench-owned row RAMs, reference counter table and response queue.

module tb_sketch_cm_multi;
    localparam int HW = 4, DW = 64, CW = 4, D = 2, CU = 1, INIT_CLEAR = 1;
    localparam int N = 1 << HW;
    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [63:0] KA = 64'h0123_4567_89AB_CDEF, LA = 64'h5;
    localparam logic [63:0] KB = 64'hFEED_0000_1234_0042, LB = 64'h9;

    typedef struct {
        logic [1:0]    op;
        logic [63:0]   key;
        logic [63:0]   lat;
        logic [CW-1:0] est;
        logic          sat;
    } vec_t;

    typedef struct {
        logic [CW-1:0] est;
        logic          sat;
        int            cyc;
    } exp_t;

    logic            clk = 1'b0, rst = 1'b0;
    logic            req_valid, req_ready, resp_valid, resp_sat;
    logic [1:0]      req_op;
    logic [DW-1:0]   req_key, req_lat;
    logic [CW-1:0]   resp_est;
    logic [D-1:0]    ram_rd_en, ram_wr_en;
    logic [D*HW-1:0] ram_rd_addr, ram_wr_addr;
    logic [D*CW-1:0] ram_rd_data, ram_wr_data;

    logic [CW-1:0]   mem [D][N];
    logic [CW-1:0]   mdl [D][N];
    logic            pre_all = 1'b0, pre_one = 1'b0;
    int              pre_row = 0, pre_idx = 0;
    logic [CW-1:0]   pre_val = '0;

    int   n_vec = 0, n_bad = 0, cyc = 0, nwr = 0;
    logic [D-1:0]    last_wr_en;
    logic [D*HW-1:0] last_wr_addr;
    logic [D*CW-1:0] last_wr_data;
    exp_t sbq[$];

    sketch_cm_multi #(.HW(HW), .DW(DW), .CW(CW), .D(D), .CU(CU), .INIT_CLEAR(INIT_CLEAR)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_key_i(req_key), .req_lat_i(req_lat),
        .resp_valid_o(resp_valid), .resp_est_o(resp_est), .resp_sat_o(resp_sat),
        .ram_rd_en_o(ram_rd_en), .ram_rd_addr_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data),
        .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr), .ram_wr_data_o(ram_wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Row RAMs: synchronous read (old data on collision), plus bench preload
    always @(posedge clk) begin
        for (int r = 0; r < D; r++) begin
            if (ram_rd_en[r]) ram_rd_data[r*CW +: CW] <= mem[r][ram_rd_addr[r*HW +: HW]];
            if (ram_wr_en[r]) mem[r][ram_wr_addr[r*HW +: HW]] <= ram_wr_data[r*CW +: CW];
        end
        if (pre_all)
            for (int r = 0; r < D; r++)
                for (int i = 0; i < N; i++) mem[r][i] <= pre_val;
        if (pre_one) mem[pre_row][pre_idx] <= pre_val;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response scoreboard and idle-write-port checks
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (resp_valid) begin
                if (sbq.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
                else begin
                    e = sbq.pop_front();
                    chk("resp_est", 64'(resp_est), 64'(e.est));
                    chk("resp_sat", 64'(resp_sat), 64'(e.sat));
                    if (e.cyc >= 0) chk("resp_latency", 64'(cyc), 64'(e.cyc));
                end
            end
            for (int r = 0; r < D; r++)
                if (!ram_wr_en[r])
                    chk("wr_idle_zero", 64'({ram_wr_addr[r*HW +: HW], ram_wr_data[r*CW +: CW]}), 64'd0);
            if (|ram_wr_en) begin
                nwr <= nwr + 1;
                last_wr_en   <= ram_wr_en;
                last_wr_addr <= ram_wr_addr;
                last_wr_data <= ram_wr_data;
            end
        end
    end

    function automatic logic [HW-1:0] hidx(input int r, input logic [63:0] key, input logic [63:0] lat);
        logic [31:0] seed, c;
        logic [63:0] m;
        seed = 32'h9E37_79B9 * 32'(r + 1);
        m    = {key[31:0], lat[31:0]} ^ {seed, seed};
        c    = 32'hFFFF_FFFF;
        for (int i = 63; i >= 0; i--)
            c = {c[30:0], 1'b0} ^ (((c[31] ^ m[i]) != 1'b0) ? 32'h04C1_1DB7 : 32'h0);
        return c[HW-1:0];
    endfunction

    task automatic model(input logic [1:0] op, input logic [63:0] key, input logic [63:0] lat,
                         output logic [CW-1:0] est, output logic sat);
        logic [HW-1:0] ix [D];
        logic [CW-1:0] mn, v;
        est = '0;
        sat = 1'b0;
        if (op == 2'b10) begin
            for (int r = 0; r < D; r++)
                for (int i = 0; i < N; i++) mdl[r][i] = '0;
        end else begin
            mn = CMAX;
            for (int r = 0; r < D; r++) begin
                ix[r] = hidx(r, key, lat);
                if (mdl[r][ix[r]] < mn) mn = mdl[r][ix[r]];
            end
            est = CMAX;
            for (int r = 0; r < D; r++) begin
                v = mdl[r][ix[r]];
                if (op == 2'b00 && v != CMAX && (CU == 0 || v == mn)) v = v + 1'b1;
                mdl[r][ix[r]] = v;
                if (v < est) est = v;
                if (v == CMAX) sat = 1'b1;
            end
        end
    endtask

    // Drive one request (held until accepted) and queue its expected response
    task automatic send(input logic [1:0] op, input logic [63:0] key, input logic [63:0] lat,
                        input logic [CW-1:0] est, input logic sat, input bit tcheck);
        int w = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        req_lat   = lat;
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        sbq.push_back('{est, sat, tcheck ? cyc + 3 : -1});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic preload(input int r, input int i, input logic [CW-1:0] v);
        pre_one = 1'b1; pre_row = r; pre_idx = i; pre_val = v;
        mdl[r][i] = v;
        @(negedge clk);
        pre_one = 1'b0;
    endtask

    // Expect one full clear sweep: every row, index 0..N-1, data 0, then RUN
    task automatic check_clear(input string nm, input bit with_resp);
        int w = 0;
        while (!(ram_wr_en == '1 && ram_wr_data == '0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk({nm, "_start"}, 64'(w < 100), 64'd1);
        for (int i = 0; i < N; i++) begin
            chk({nm, "_en"}, 64'(ram_wr_en), 64'((1 << D) - 1));
            chk({nm, "_data"}, 64'(ram_wr_data), 64'd0);
            for (int r = 0; r < D; r++) chk({nm, "_addr"}, 64'(ram_wr_addr[r*HW +: HW]), 64'(i));
            chk({nm, "_ready"}, 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        chk({nm, "_end_en"}, 64'(ram_wr_en), 64'd0);
        chk({nm, "_end_ready"}, 64'(req_ready), 64'd1);
        chk({nm, "_end_resp"}, 64'(resp_valid), 64'(with_resp));
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_ready"}, 64'(req_ready), 64'd0);
        chk({nm, "_resp"}, 64'({resp_valid, resp_est, resp_sat}), 64'd0);
        chk({nm, "_rd"}, 64'({ram_rd_en, ram_rd_addr}), 64'd0);
        chk({nm, "_wr"}, 64'({ram_wr_en, ram_wr_addr, ram_wr_data}), 64'd0);
    endtask

    vec_t t1[4];
    vec_t t2[40];

    initial begin
        logic [CW-1:0] e;
        logic          s;
        int            snap, w;
        logic [HW-1:0] a, b;

        req_valid = 1'b0; req_op = '0; req_key = '0; req_lat = '0;
        // fill RAM with junk during reset so the init sweep is observable
        @(negedge clk);
        pre_all = 1'b1; pre_val = 4'd9;
        @(negedge clk);
        pre_all = 1'b0;
        check_reset_outputs("reset");
        rst = 1'b1;
        for (int r = 0; r < D; r++) for (int i = 0; i < N; i++) mdl[r][i] = '0;
        check_clear("init", 1'b0);

        // same key inserted three times back-to-back, then queried
        t1[0] = '{2'b00, KA, LA, 4'd1, 1'b0};
        t1[1] = '{2'b00, KA, LA, 4'd2, 1'b0};
        t1[2] = '{2'b00, KA, LA, 4'd3, 1'b0};
        t1[3] = '{2'b01, KA, LA, 4'd3, 1'b0};
        for (int i = 0; i < 4; i++) model(t1[i].op, t1[i].key, t1[i].lat, e, s);
        for (int i = 0; i < 4; i++) send(t1[i].op, t1[i].key, t1[i].lat, t1[i].est, t1[i].sat, 1'b1);
        idle(5);

        // mixed traffic, mostly on one key so it reaches saturation
        for (int i = 0; i < 40; i++) begin
            bit kb;
            kb = ($urandom_range(0, 3) == 0);
            t2[i].key = kb ? KB : KA;
            t2[i].lat = kb ? LB : LA;
            t2[i].op  = (i % 6 == 5) ? 2'b01 : ((i % 11 == 10) ? 2'b11 : 2'b00);
            model(t2[i].op, t2[i].key, t2[i].lat, t2[i].est, t2[i].sat);
        end
        for (int i = 0; i < 40; i++) begin
            send(t2[i].op, t2[i].key, t2[i].lat, t2[i].est, t2[i].sat, 1'b1);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(6);

        // every counter at max: insert must not write and reports saturation
        pre_all = 1'b1; pre_val = CMAX;
        @(negedge clk);
        pre_all = 1'b0;
        for (int r = 0; r < D; r++) for (int i = 0; i < N; i++) mdl[r][i] = CMAX;
        snap = nwr;
        model(2'b00, KA, LA, e, s);
        send(2'b00, KA, LA, 4'd15, 1'b1, 1'b1);
        idle(5);
        chk("sat_no_write", 64'(nwr - snap), 64'd0);

        // conservative update: only the row holding the minimum is bumped
        a = hidx(0, KA, LA);
        b = hidx(1, KA, LA);
        preload(0, int'(a), 4'd5);
        preload(1, int'(b), 4'd2);
        idle(2);
        snap = nwr;
        model(2'b00, KA, LA, e, s);
        send(2'b00, KA, LA, 4'd3, 1'b0, 1'b1);
        idle(5);
        chk("cu_write_count", 64'(nwr - snap), 64'd1);
        chk("cu_write_rows", 64'(last_wr_en), 64'b10);
        chk("cu_write_addr", 64'(last_wr_addr[HW +: HW]), 64'(b));
        chk("cu_write_data", 64'(last_wr_data[CW +: CW]), 64'd3);
        chk("cu_row0_kept", 64'(mem[0][a]), 64'd5);
        chk("cu_row1_new", 64'(mem[1][b]), 64'd3);

        // clear behind two in-flight inserts, query held until clear completes
        for (int r = 0; r < D; r++) for (int i = 0; i < N; i++) mdl[r][i] = 4'd1;
        pre_all = 1'b1; pre_val = 4'd1;
        @(negedge clk);
        pre_all = 1'b0;
        send(2'b00, KA, LA, 4'd2, 1'b0, 1'b1);
        send(2'b00, KB, LB, (hidx(0, KA, LA) == hidx(0, KB, LB) && hidx(1, KA, LA) == hidx(1, KB, LB)) ? 4'd3 : 4'd2, 1'b0, 1'b1);
        send(2'b10, '0, '0, 4'd0, 1'b0, 1'b0);
        model(2'b10, '0, '0, e, s);
        fork
            send(2'b01, KA, LA, 4'd0, 1'b0, 1'b1);
            check_clear("clear", 1'b1);
        join
        idle(5);

        // reset in the middle of a clear sweep aborts it; init sweep restarts
        send(2'b10, '0, '0, 4'd0, 1'b0, 1'b0);
        w = 0;
        while (!(ram_wr_en[0] && ram_wr_addr[HW-1:0] == 4'd7 && ram_wr_data == '0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("clear_reach_idx7", 64'(w < 100), 64'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("midclear_reset");
        sbq.delete();
        model(2'b10, '0, '0, e, s);
        idle(2);
        check_reset_outputs("midclear_hold");
        rst = 1'b1;
        check_clear("reinit", 1'b0);
        send(2'b01, KA, LA, 4'd0, 1'b0, 1'b1);

        w = 0;
        while (sbq.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        idle(2);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
